// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/writeback
// and drives all datapath controls from the IR opcode.
module mc_control_fsm #(
    parameter int OP_W = 6,
    parameter int ST_W = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [OP_W-1:0] i_op,
    input  logic            i_zero,
    input  logic            i_mem_ready,
    output logic            o_con_iord,
    output logic            o_con_memread,
    output logic            o_con_memwrite,
    output logic            o_con_irwrite,
    output logic            o_con_pcen,
    output logic [1:0]      o_con_pcsrc,
    output logic            o_con_alusrca,
    output logic [1:0]      o_con_alusrcb,
    output logic [2:0]      o_con_aluop,
    output logic            o_con_signext,
    output logic            o_con_regwrite,
    output logic            o_con_regdst,
    output logic            o_con_memtoreg,
    output logic            o_illegal,
    output logic [ST_W-1:0] o_state
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMRD    = 4'd4,
        MEMWB    = 4'd5,
        MEMWR    = 4'd6,
        RTYPE_EX = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        IMM_EX   = 4'd10,
        IMMWB    = 4'd11,
        JUMP     = 4'd12,
        TRAP     = 4'd13
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       jump_pcen;
    } ctrl_t;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_ADDIU = OP_W'(6'b001001);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(6'b001111);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);

    state_t state;
    state_t nxt;
    ctrl_t  ctrl;
    logic   illegal;
    logic   sx;
    logic   branch_take;

    // Control word for the state being entered, so it can be registered.
    function automatic ctrl_t decode_ctrl(input state_t st, input logic [OP_W-1:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            FETCH: begin
                c.memread = 1'b1;
                c.alusrcb = 2'b01;
            end
            DECODE: c.alusrcb = 2'b11;
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            MEMRD: begin
                c.iord    = 1'b1;
                c.memread = 1'b1;
            end
            MEMWB: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            RTYPE_EX: begin
                c.alusrca = 1'b1;
                c.aluop   = 3'b010;
            end
            ALUWB: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
            end
            BRANCH: begin
                c.alusrca = 1'b1;
                c.aluop   = 3'b001;
                c.pcsrc   = 2'b01;
            end
            IMM_EX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                case (op)
                    OP_SLTI: c.aluop = 3'b101;
                    OP_ANDI: c.aluop = 3'b011;
                    OP_ORI:  c.aluop = 3'b100;
                    OP_LUI:  c.aluop = 3'b110;
                    default: c.aluop = 3'b000;
                endcase
            end
            IMMWB: c.regwrite = 1'b1;
            JUMP: begin
                c.pcsrc     = 2'b10;
                c.jump_pcen = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt = state;
        case (state)
            IDLE:   nxt = FETCH;
            FETCH:  nxt = i_mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (i_op)
                    OP_LW, OP_SW:   nxt = MEMADR;
                    OP_RTYPE:       nxt = RTYPE_EX;
                    OP_BEQ, OP_BNE: nxt = BRANCH;
                    OP_ADDI, OP_ADDIU, OP_SLTI,
                    OP_ANDI, OP_ORI, OP_LUI: nxt = IMM_EX;
                    OP_J:           nxt = JUMP;
                    default:        nxt = TRAP;
                endcase
            end
            MEMADR:   nxt = (i_op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:    nxt = i_mem_ready ? MEMWB : MEMRD;
            MEMWB:    nxt = FETCH;
            MEMWR:    nxt = i_mem_ready ? FETCH : MEMWR;
            RTYPE_EX: nxt = ALUWB;
            ALUWB:    nxt = FETCH;
            BRANCH:   nxt = FETCH;
            IMM_EX:   nxt = IMMWB;
            IMMWB:    nxt = FETCH;
            JUMP:     nxt = FETCH;
            TRAP:     nxt = FETCH;
            default:  nxt = IDLE;
        endcase
    end

    // Reset clears the registered control word, so memory strobes drop immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ctrl    <= '0;
            illegal <= 1'b0;
        end else begin
            state <= nxt;
            ctrl  <= decode_ctrl(nxt, i_op);
            if (nxt == TRAP) begin
                illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        case (i_op)
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI: sx = 1'b1;
            default: sx = 1'b0;
        endcase
        if (i_op == OP_BEQ) begin
            branch_take = i_zero;
        end else if (i_op == OP_BNE) begin
            branch_take = ~i_zero;
        end else begin
            branch_take = 1'b0;
        end
    end

    // Handshake- and flag-dependent strobes are gated from the live inputs.
    assign o_con_irwrite  = (state == FETCH) & i_mem_ready;
    assign o_con_pcen     = ((state == FETCH) & i_mem_ready) | ctrl.jump_pcen |
                            ((state == BRANCH) & branch_take);
    assign o_con_signext  = (state != IDLE) & sx;
    assign o_con_iord     = ctrl.iord;
    assign o_con_memread  = ctrl.memread;
    assign o_con_memwrite = ctrl.memwrite;
    assign o_con_pcsrc    = ctrl.pcsrc;
    assign o_con_alusrca  = ctrl.alusrca;
    assign o_con_alusrcb  = ctrl.alusrcb;
    assign o_con_aluop    = ctrl.aluop;
    assign o_con_regwrite = ctrl.regwrite;
    assign o_con_regdst   = ctrl.regdst;
    assign o_con_memtoreg = ctrl.memtoreg;
    assign o_illegal      = illegal;
    assign o_state        = ST_W'(state);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: instruction-level expected traces
// compared every cycle, plus hand-computed spot checks.
module tb_mc_control_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       pcen;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic       signext;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       illegal;
    } obs_t;

    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] J     = 6'b000010;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] BNE   = 6'b000101;
    localparam logic [5:0] ADDI  = 6'b001000;
    localparam logic [5:0] ADDIU = 6'b001001;
    localparam logic [5:0] SLTI  = 6'b001010;
    localparam logic [5:0] ANDI  = 6'b001100;
    localparam logic [5:0] ORI   = 6'b001101;
    localparam logic [5:0] LUI   = 6'b001111;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] BAD   = 6'b111111;

    logic       clock;
    logic       reset;
    logic [5:0] i_op;
    logic       i_zero;
    logic       i_mem_ready;
    logic       o_con_iord, o_con_memread, o_con_memwrite, o_con_irwrite, o_con_pcen;
    logic [1:0] o_con_pcsrc;
    logic       o_con_alusrca;
    logic [1:0] o_con_alusrcb;
    logic [2:0] o_con_aluop;
    logic       o_con_signext, o_con_regwrite, o_con_regdst, o_con_memtoreg;
    logic       o_illegal;
    logic [3:0] o_state;

    int    passCount = 0;
    int    checkCount = 0;
    logic  illegalModel = 1'b0;
    obs_t  expQ[$];
    string labelQ[$];
    obs_t  obsLog[$];
    obs_t  cmpObs;
    obs_t  cmpExp;
    string cmpLbl;

    mc_control_fsm dut (
        .clock(clock), .reset(reset), .i_op(i_op), .i_zero(i_zero),
        .i_mem_ready(i_mem_ready), .o_con_iord(o_con_iord),
        .o_con_memread(o_con_memread), .o_con_memwrite(o_con_memwrite),
        .o_con_irwrite(o_con_irwrite), .o_con_pcen(o_con_pcen),
        .o_con_pcsrc(o_con_pcsrc), .o_con_alusrca(o_con_alusrca),
        .o_con_alusrcb(o_con_alusrcb), .o_con_aluop(o_con_aluop),
        .o_con_signext(o_con_signext), .o_con_regwrite(o_con_regwrite),
        .o_con_regdst(o_con_regdst), .o_con_memtoreg(o_con_memtoreg),
        .o_illegal(o_illegal), .o_state(o_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic obs_t observe();
        obs_t o;
        o.st = o_state;           o.iord = o_con_iord;
        o.memread = o_con_memread; o.memwrite = o_con_memwrite;
        o.irwrite = o_con_irwrite; o.pcen = o_con_pcen;
        o.pcsrc = o_con_pcsrc;     o.alusrca = o_con_alusrca;
        o.alusrcb = o_con_alusrcb; o.aluop = o_con_aluop;
        o.signext = o_con_signext; o.regwrite = o_con_regwrite;
        o.regdst = o_con_regdst;   o.memtoreg = o_con_memtoreg;
        o.illegal = o_illegal;
        return o;
    endfunction

    function automatic obs_t base(input logic [3:0] st, input logic sx);
        obs_t e;
        e = '0;
        e.st = st;
        e.signext = sx;
        e.illegal = illegalModel;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // One clock of stimulus with the outputs the instruction must show in it.
    task automatic applyStimulus(input obs_t e, input logic [5:0] op, input logic zero,
                                 input logic ready, input string label);
        @(posedge clock);
        #1;
        i_op = op;
        i_zero = zero;
        i_mem_ready = ready;
        expQ.push_back(e);
        labelQ.push_back(label);
    endtask

    task automatic releaseReset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        illegalModel = 1'b0;
        expQ.push_back(obs_t'(0));
        labelQ.push_back("idle_after_reset");
        @(negedge clock);
        #1;
    endtask

    task automatic runFront(input logic [5:0] op, input int fWait, input logic zero, input logic sx);
        obs_t e;
        for (int k = 0; k < fWait; k++) begin
            e = base(4'd1, sx); e.memread = 1'b1; e.alusrcb = 2'b01;
            applyStimulus(e, op, zero, 1'b0, "fetch_wait");
        end
        e = base(4'd1, sx); e.memread = 1'b1; e.alusrcb = 2'b01;
        e.irwrite = 1'b1; e.pcen = 1'b1;
        applyStimulus(e, op, zero, 1'b1, "fetch");
        e = base(4'd2, sx); e.alusrcb = 2'b11;
        applyStimulus(e, op, zero, 1'b1, "decode");
    endtask

    task automatic runInstr(input logic [5:0] op, input int fWait, input int mWait, input logic zero);
        obs_t e;
        logic sx;
        sx = (op inside {LW, SW, BEQ, BNE, ADDI, ADDIU, SLTI});
        obsLog.delete();
        runFront(op, fWait, zero, sx);
        case (op)
            LW, SW: begin
                e = base(4'd3, sx); e.alusrca = 1'b1; e.alusrcb = 2'b10;
                applyStimulus(e, op, zero, 1'b1, "memadr");
                for (int k = 0; k <= mWait; k++) begin
                    e = base((op == LW) ? 4'd4 : 4'd6, sx); e.iord = 1'b1;
                    if (op == LW) e.memread = 1'b1; else e.memwrite = 1'b1;
                    applyStimulus(e, op, zero, (k == mWait), "mem_access");
                end
                if (op == LW) begin
                    e = base(4'd5, sx); e.regwrite = 1'b1; e.memtoreg = 1'b1;
                    applyStimulus(e, op, zero, 1'b1, "memwb");
                end
            end
            RTYPE: begin
                e = base(4'd7, sx); e.alusrca = 1'b1; e.aluop = 3'b010;
                applyStimulus(e, op, zero, 1'b1, "rtype_ex");
                e = base(4'd8, sx); e.regwrite = 1'b1; e.regdst = 1'b1;
                applyStimulus(e, op, zero, 1'b1, "aluwb");
            end
            BEQ, BNE: begin
                e = base(4'd9, sx); e.alusrca = 1'b1; e.aluop = 3'b001; e.pcsrc = 2'b01;
                e.pcen = (op == BEQ) ? zero : ~zero;
                applyStimulus(e, op, zero, 1'b1, "branch");
            end
            ADDI, ADDIU, SLTI, ANDI, ORI, LUI: begin
                e = base(4'd10, sx); e.alusrca = 1'b1; e.alusrcb = 2'b10;
                e.aluop = (op == SLTI) ? 3'b101 : (op == ANDI) ? 3'b011 :
                          (op == ORI) ? 3'b100 : (op == LUI) ? 3'b110 : 3'b000;
                applyStimulus(e, op, zero, 1'b1, "imm_ex");
                e = base(4'd11, sx); e.regwrite = 1'b1;
                applyStimulus(e, op, zero, 1'b1, "immwb");
            end
            J: begin
                e = base(4'd12, sx); e.pcsrc = 2'b10; e.pcen = 1'b1;
                applyStimulus(e, op, zero, 1'b1, "jump");
            end
            default: begin
                illegalModel = 1'b1;
                e = base(4'd13, sx);
                applyStimulus(e, op, zero, 1'b1, "trap");
            end
        endcase
        @(negedge clock);
        #1;
    endtask

    // Every cycle with a queued expectation is compared on the falling edge.
    always @(negedge clock) begin
        if (expQ.size() > 0) begin
            cmpExp = expQ.pop_front();
            cmpLbl = labelQ.pop_front();
            cmpObs = observe();
            obsLog.push_back(cmpObs);
            checkOutput(cmpLbl, 32'(cmpObs), 32'(cmpExp));
        end
    end

    initial begin
        logic [3:0] lwStates [8];
        logic [7:0] rwBits;
        logic [7:0] mtrBits;
        lwStates = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd5};
        reset = 1'b1;
        i_op = 6'd0;
        i_zero = 1'b0;
        i_mem_ready = 1'b0;
        #3;
        checkOutput("reset_all_zero", 32'(observe()), 32'd0);
        releaseReset();

        runInstr(LW, 2, 1, 1'b0);
        checkOutput("lw_length", obsLog.size(), 32'd8);
        rwBits = '0;
        mtrBits = '0;
        for (int i = 0; i < 8 && i < obsLog.size(); i++) begin
            checkOutput("lw_state_seq", 32'(obsLog[i].st), 32'(lwStates[i]));
            rwBits[i] = obsLog[i].regwrite;
            mtrBits[i] = obsLog[i].memtoreg;
        end
        checkOutput("lw_first_fetch_memread", 32'(obsLog[0].memread), 32'd1);
        checkOutput("lw_regwrite_only_memwb", 32'(rwBits), 32'h80);
        checkOutput("lw_memtoreg_only_memwb", 32'(mtrBits), 32'h80);
        checkOutput("lw_signext", 32'(obsLog[4].signext), 32'd1);

        runInstr(BEQ, 0, 0, 1'b1);
        checkOutput("beq_length", obsLog.size(), 32'd3);
        checkOutput("beq_pcen", 32'(obsLog[2].pcen), 32'd1);
        checkOutput("beq_pcsrc", 32'(obsLog[2].pcsrc), 32'd1);
        runInstr(BNE, 0, 0, 1'b1);
        checkOutput("bne_length", obsLog.size(), 32'd3);
        checkOutput("bne_pcen", 32'(obsLog[2].pcen), 32'd0);
        runInstr(BNE, 1, 0, 1'b0);
        runInstr(BEQ, 0, 0, 1'b0);

        runInstr(ANDI, 0, 0, 1'b0);
        checkOutput("andi_signext", 32'(obsLog[2].signext), 32'd0);
        checkOutput("andi_aluop", 32'(obsLog[2].aluop), 32'd3);
        checkOutput("andi_regdst_rt", 32'({obsLog[3].regwrite, obsLog[3].regdst}), 32'b10);
        runInstr(ADDI, 0, 0, 1'b0);
        checkOutput("addi_signext", 32'(obsLog[2].signext), 32'd1);
        checkOutput("addi_aluop", 32'(obsLog[2].aluop), 32'd0);
        checkOutput("addi_regdst_rt", 32'({obsLog[3].regwrite, obsLog[3].regdst}), 32'b10);

        runInstr(ADDIU, 0, 0, 1'b0);
        runInstr(SLTI, 1, 0, 1'b0);
        runInstr(ORI, 0, 0, 1'b0);
        runInstr(LUI, 0, 0, 1'b0);
        runInstr(RTYPE, 0, 0, 1'b0);
        checkOutput("rtype_length", obsLog.size(), 32'd4);
        runInstr(J, 0, 0, 1'b0);
        checkOutput("j_length", obsLog.size(), 32'd3);
        runInstr(SW, 0, 2, 1'b0);
        checkOutput("sw_length", obsLog.size(), 32'd6);

        runInstr(BAD, 0, 0, 1'b0);
        checkOutput("trap_state", 32'(obsLog[2].st), 32'd13);
        runInstr(RTYPE, 0, 0, 1'b0);
        checkOutput("illegal_sticky", 32'(obsLog[3].illegal), 32'd1);
        runInstr(LW, 0, 0, 1'b0);
        checkOutput("illegal_sticky_pin", 32'(o_illegal), 32'd1);

        // sw interrupted by reset while its write is still waiting
        obsLog.delete();
        runFront(SW, 0, 1'b0, 1'b1);
        begin
            obs_t e;
            e = base(4'd3, 1'b1); e.alusrca = 1'b1; e.alusrcb = 2'b10;
            applyStimulus(e, SW, 1'b0, 1'b0, "memadr");
            e = base(4'd6, 1'b1); e.iord = 1'b1; e.memwrite = 1'b1;
            applyStimulus(e, SW, 1'b0, 1'b0, "memwr_wait");
        end
        @(negedge clock);
        #1;
        checkOutput("sw_memwrite_before_reset", 32'(obsLog[3].memwrite), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("sw_reset_memwrite", 32'(o_con_memwrite), 32'd0);
        checkOutput("sw_reset_state", 32'(o_state), 32'd0);
        checkOutput("sw_reset_all_zero", 32'(observe()), 32'd0);
        releaseReset();
        checkOutput("illegal_cleared", 32'(o_illegal), 32'd0);
        runInstr(RTYPE, 0, 0, 1'b0);
        checkOutput("after_reset_fetch", 32'(obsLog[0].st), 32'd1);

        checkOutput("queue_drained", expQ.size(), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multicycle MIPS main controller. Sequences the shared datapath (ALU, sign extender, IR, PC, register file, unified memory port) through fetch/decode/execute/writeback states. Drives the sign-extend select `o_con_signext` and all other datapath controls from the IR opcode. Sits beside the datapath top; the memory port handshakes through `i_mem_ready`.

Parameters:
OP_W, 6, opcode width
ST_W, 4, state register width (exported on `o_state` for debug)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
i_op  in  6  IR[31:26]; stable from end of FETCH until next FETCH
i_zero  in  1  ALU zero flag
i_mem_ready  in  1  memory access completes this cycle
o_con_iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
o_con_memread  out  1  memory read request
o_con_memwrite  out  1  memory write request
o_con_irwrite  out  1  IR load
o_con_pcen  out  1  PC load enable
o_con_pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
o_con_alusrca  out  1  0 PC, 1 regA
o_con_alusrcb  out  2  00 regB, 01 const 4, 10 imm, 11 imm<<2
o_con_aluop  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt, 110 lui
o_con_signext  out  1  1 sign-extend, 0 zero-extend immediate
o_con_regwrite  out  1  register file write
o_con_regdst  out  1  0 rt, 1 rd
o_con_memtoreg  out  1  0 ALUOut, 1 MDR
o_illegal  out  1  sticky illegal-opcode flag
o_state  out  ST_W  current state

Behaviour:
- State register updates on the rising edge of `clock`. `reset` asynchronously forces IDLE and clears `o_illegal`.
- All outputs are 0 in IDLE, so every output resets to 0. IDLE always moves to FETCH on the next cycle.
- State encodings:
  - IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6
  - RTYPE_EX=7, ALUWB=8, BRANCH=9, IMM_EX=10, IMMWB=11, JUMP=12, TRAP=13
  - 14 and 15 go to IDLE.
- Any control not listed for a state is 0. Outputs are Moore-decoded from the state plus the gating noted.
- FETCH: memread=1, alusrcb=01, aluop=add.
  - While i_mem_ready=0: stay; irwrite=pcen=0.
  - When i_mem_ready=1: irwrite=1, pcen=1, go to DECODE.
- DECODE: alusrcb=11, aluop=add (branch target to ALUOut). Next state by i_op:
  - 100011/101011 -> MEMADR
  - 000000 -> RTYPE_EX
  - 000100/000101 -> BRANCH
  - 001000/001001/001010/001100/001101/001111 -> IMM_EX
  - 000010 -> JUMP
  - any other -> TRAP
- MEMADR: alusrca=1, alusrcb=10, aluop=add. lw -> MEMRD, sw -> MEMWR.
- MEMRD: iord=1, memread=1. Hold until i_mem_ready=1, then MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. Then FETCH.
- MEMWR: iord=1, memwrite=1. Hold until i_mem_ready=1, then FETCH.
- RTYPE_EX: alusrca=1, alusrcb=00, aluop=funct. Then ALUWB.
- ALUWB: regwrite=1, regdst=1. Then FETCH.
- BRANCH: alusrca=1, aluop=sub, pcsrc=01.
  - pcen = i_zero for beq; pcen = ~i_zero for bne.
  - Then FETCH.
- IMM_EX: alusrca=1, alusrcb=10. aluop by opcode:
  - addi/addiu -> add
  - slti -> slt
  - andi -> and
  - ori -> or
  - lui -> lui
  - Then IMMWB.
- IMMWB: regwrite=1, regdst=0, memtoreg=0. Then FETCH.
- JUMP: pcsrc=10, pcen=1. Then FETCH.
- TRAP: sets `o_illegal`=1 (sticky until reset); no datapath writes; then FETCH.
- `o_con_signext`:
  - 0 in IDLE.
  - Otherwise a combinational function of i_op: 1 for lw, sw, beq, bne, addi, addiu, slti; 0 for andi, ori, lui, R-type, j, illegal.
- `i_mem_ready` is ignored outside FETCH, MEMRD and MEMWR.
- Reset mid-access drops memread/memwrite asynchronously; no partial write-enable pulse survives reset.
- Cycles per instruction, with zero memory wait:
  - lw 5; sw 4; R-type 4; immediate ops 4; beq/bne 3; j 3.
  - Each memory wait cycle adds 1.

Test Plan:
1. Assert reset during any state -> o_state=0 and all outputs 0 immediately. Release -> FETCH next cycle, memread=1.
2. lw (op=100011) with i_mem_ready low for 2 cycles in FETCH and 1 cycle in MEMRD -> state sequence 1,1,1,2,3,4,4,5,1; regwrite=1 and memtoreg=1 only in MEMWB; o_con_signext=1.
3. beq with i_zero=1 -> pcen=1, pcsrc=01 in BRANCH. bne with i_zero=1 -> pcen=0. Both return to FETCH after 3 cycles.
4. andi (001100) -> signext=0, aluop=011. addi (001000) -> signext=1, aluop=000. Both write rt (regdst=0) in IMMWB.
5. Opcode 111111 -> TRAP then FETCH; o_illegal stays 1 across subsequent instructions until reset.
6. sw with reset asserted while in MEMWR with i_mem_ready=0 -> memwrite deasserts asynchronously; FETCH after release, no write-back.
